// File: rtl/cursor_painter.sv
// Cursor overlay painter: draws a transient cursor into a two-bank framebuffer.
// Before each new draw it restores the pixel under the previous cursor from the
// backing copy. It also handles permanent paints and full-buffer clears.
module cursor_painter #(
   parameter logic [11:0] CURSOR_COLOR = 12'hFFF,
   parameter int unsigned CLEAR_LAST   = 2047
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [5:0]  cursor_x,
   input  logic [5:0]  cursor_y,
   input  logic [11:0] color,
   output logic [11:0] addr_write,
   output logic        wr0,
   output logic        wr1,
   output logic [11:0] wdata,
   output logic        paint_permanent,
   input  logic [11:0] b_rdata0,
   input  logic [11:0] b_rdata1,
   output logic        busy
);

   localparam int unsigned AW = 12;
   localparam int unsigned CW = 12;
   localparam int unsigned PW = 6;

   localparam logic [1:0] OP_PAINT = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_MOVE  = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD_OLD = 3'd1,
      S_WR_OLD = 3'd2,
      S_DRAW   = 3'd3,
      S_CLEAR  = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] wdata_q, wdata_d;
   logic          wr0_q, wr0_d, wr1_q, wr1_d, perm_q, perm_d;
   logic          ready_q, ready_d, busy_q;
   logic [1:0]    op_q, op_d;
   logic [PW-1:0] nx_q, nx_d, ny_q, ny_d, ox_q, ox_d, oy_q, oy_d;
   logic [CW-1:0] color_q, color_d;
   logic          drawn_q, drawn_d;

   logic          accept_c;
   logic [1:0]    sel_op_c;
   logic [PW-1:0] sel_x_c, sel_y_c;
   logic [CW-1:0] sel_color_c;

   // Pixel to bank-local word address; bank select is y[5].
   function automatic logic [AW-1:0] pix_addr(input logic [PW-1:0] x, input logic [PW-1:0] y);
      return {1'b0, y[4:0], x};
   endfunction

   assign accept_c    = cmd_valid & ready_q;
   assign sel_op_c    = (state_q == S_IDLE) ? cmd_op   : op_q;
   assign sel_x_c     = (state_q == S_IDLE) ? cursor_x : nx_q;
   assign sel_y_c     = (state_q == S_IDLE) ? cursor_y : ny_q;
   assign sel_color_c = (state_q == S_IDLE) ? color    : color_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               if (cmd_op == OP_MOVE || cmd_op == OP_PAINT) state_d = drawn_q ? S_RD_OLD : S_DRAW;
               else if (cmd_op == OP_CLEAR)                 state_d = S_CLEAR;
            end
         end
         S_RD_OLD: state_d = S_WR_OLD;
         S_WR_OLD: state_d = S_DRAW;
         S_DRAW:   state_d = S_IDLE;
         S_CLEAR:  if (addr_q == AW'(CLEAR_LAST)) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and captured command fields.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr0_d   = 1'b0;
      wr1_d   = 1'b0;
      perm_d  = 1'b0;
      ready_d = (state_d == S_IDLE);
      op_d    = op_q;
      nx_d    = nx_q;
      ny_d    = ny_q;
      color_d = color_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      drawn_d = drawn_q;

      if (accept_c) begin
         op_d    = cmd_op;
         nx_d    = cursor_x;
         ny_d    = cursor_y;
         color_d = color;
      end

      case (state_d)
         S_RD_OLD: addr_d = pix_addr(ox_q, oy_q);
         S_WR_OLD: begin
            wr0_d   = ~oy_q[5];
            wr1_d   = oy_q[5];
            wdata_d = oy_q[5] ? b_rdata1 : b_rdata0;
         end
         S_DRAW: begin
            addr_d  = pix_addr(sel_x_c, sel_y_c);
            wr0_d   = ~sel_y_c[5];
            wr1_d   = sel_y_c[5];
            wdata_d = (sel_op_c == OP_PAINT) ? sel_color_c : CURSOR_COLOR;
            perm_d  = (sel_op_c == OP_PAINT);
         end
         S_CLEAR: begin
            addr_d  = (state_q == S_CLEAR) ? addr_q + AW'(1) : '0;
            wr0_d   = 1'b1;
            wr1_d   = 1'b1;
            wdata_d = sel_color_c;
            perm_d  = 1'b1;
         end
         default: ;
      endcase

      if (state_q == S_DRAW) begin
         ox_d    = nx_q;
         oy_d    = ny_q;
         drawn_d = 1'b1;
      end
      if (state_q == S_CLEAR && state_d == S_IDLE) drawn_d = 1'b0;
   end

   // Output and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wr0_q   <= 1'b0;
         wr1_q   <= 1'b0;
         perm_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         op_q    <= '0;
         nx_q    <= '0;
         ny_q    <= '0;
         color_q <= '0;
         ox_q    <= '0;
         oy_q    <= '0;
         drawn_q <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr0_q   <= wr0_d;
         wr1_q   <= wr1_d;
         perm_q  <= perm_d;
         ready_q <= ready_d;
         busy_q  <= ~ready_d;
         op_q    <= op_d;
         nx_q    <= nx_d;
         ny_q    <= ny_d;
         color_q <= color_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         drawn_q <= drawn_d;
      end
   end

   assign cmd_ready       = ready_q;
   assign busy            = busy_q;
   assign addr_write      = addr_q;
   assign wr0             = wr0_q;
   assign wr1             = wr1_q;
   assign wdata           = wdata_q;
   assign paint_permanent = perm_q;

endmodule

// File: tb/tb_cursor_painter.sv
// Scoreboard bench for cursor_painter: driver pushes expected writes, monitor pops.
module tb_cursor_painter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [5:0]  cursor_x, cursor_y;
   logic [11:0] color;
   logic [11:0] addr_write;
   logic        wr0, wr1;
   logic [11:0] wdata;
   logic        paint_permanent;
   logic [11:0] b_rdata0, b_rdata1;
   logic        busy;

   cursor_painter dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cursor_x(cursor_x), .cursor_y(cursor_y), .color(color),
      .addr_write(addr_write), .wr0(wr0), .wr1(wr1), .wdata(wdata),
      .paint_permanent(paint_permanent), .b_rdata0(b_rdata0), .b_rdata1(b_rdata1),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] addr;
      logic        w0;
      logic        w1;
      logic [11:0] data;
      logic        perm;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          tests = 0;
   int          failed = 0;
   int          cyc = 0;
   int unsigned seed;
   logic        fill;

   // Backing memory seen by the DUT, and the bench's own reference copy.
   logic [11:0] bmem0[2048], bmem1[2048];
   logic [11:0] mm0[2048],   mm1[2048];

   // Reference model state.
   logic        m_drawn;
   logic [5:0]  m_ox, m_oy;

   function automatic logic [11:0] init_val(input int b, input int i);
      logic [31:0] t;
      if (b == 0 && i == 'h0C5) return 12'h123;
      t = 32'(i) * 32'd40503 + 32'(b) * 32'd7919 + seed;
      return t[14:3];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   assign b_rdata0 = bmem0[addr_write[10:0]];
   assign b_rdata1 = bmem1[addr_write[10:0]];

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 2048; i++) begin
            bmem0[i] <= init_val(0, i);
            bmem1[i] <= init_val(1, i);
         end
      end else if (paint_permanent) begin
         if (wr0) bmem0[addr_write[10:0]] <= wdata;
         if (wr1) bmem1[addr_write[10:0]] <= wdata;
      end
   end

   // Monitor: every presented write must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      tests++;
      if (busy !== ~cmd_ready) begin
         failed++;
         $display("FAIL busy_vs_ready cyc=%0d busy=%b cmd_ready=%b", cyc, busy, cmd_ready);
      end
      if (wr0 !== 1'b0 || wr1 !== 1'b0) begin
         tests++;
         if (q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_write cyc=%0d addr=%h wr0=%b wr1=%b data=%h", cyc, addr_write, wr0, wr1, wdata);
         end else begin
            e = q.pop_front();
            if (addr_write !== e.addr || wr0 !== e.w0 || wr1 !== e.w1 || wdata !== e.data ||
                paint_permanent !== e.perm || cyc != e.cyc || busy !== 1'b1) begin
               failed++;
               $display("FAIL write got addr=%h w0=%b w1=%b data=%h perm=%b cyc=%0d busy=%b want addr=%h w0=%b w1=%b data=%h perm=%b cyc=%0d busy=1",
                        addr_write, wr0, wr1, wdata, paint_permanent, cyc, busy,
                        e.addr, e.w0, e.w1, e.data, e.perm, e.cyc);
            end
            if (e.perm) begin
               if (e.w0) mm0[e.addr[10:0]] = e.data;
               if (e.w1) mm1[e.addr[10:0]] = e.data;
            end
         end
      end
   end

   // Reference model: expected writes for a command accepted at the edge after cycle n.
   task automatic model(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                        input logic [11:0] c, input int n);
      exp_t e;
      int   off;
      off = 1;
      if (op == 2'b00 || op == 2'b01) begin
         if (m_drawn) begin
            e.addr = 12'(m_oy % 32) * 12'd64 + 12'(m_ox);
            e.w0   = (m_oy < 6'd32);
            e.w1   = (m_oy >= 6'd32);
            e.data = e.w1 ? mm1[e.addr[10:0]] : mm0[e.addr[10:0]];
            e.perm = 1'b0;
            e.cyc  = n + 2;
            q.push_back(e);
            off = 3;
         end
         e.addr = 12'(y % 32) * 12'd64 + 12'(x);
         e.w0   = (y < 6'd32);
         e.w1   = (y >= 6'd32);
         e.data = (op == 2'b01) ? c : 12'hFFF;
         e.perm = (op == 2'b01);
         e.cyc  = n + off;
         q.push_back(e);
         m_drawn = 1'b1;
         m_ox    = x;
         m_oy    = y;
      end else if (op == 2'b10) begin
         for (int a = 0; a < 2048; a++) begin
            e.addr = 12'(a);
            e.w0   = 1'b1;
            e.w1   = 1'b1;
            e.data = c;
            e.perm = 1'b1;
            e.cyc  = n + 1 + a;
            q.push_back(e);
         end
         m_drawn = 1'b0;
      end
   endtask

   // Present a command (held through busy) until it is accepted.
   task automatic issue(input logic [1:0] op, input logic [5:0] x, input logic [5:0] y,
                        input logic [11:0] c);
      int w;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cursor_x  = x;
      cursor_y  = y;
      color     = c;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (cmd_ready !== 1'b1) begin
         failed++;
         $display("FAIL accept_timeout op=%0d waited=%0d cycles cmd_ready=%b want 1", op, w, cmd_ready);
         cmd_valid = 1'b0;
      end else begin
         model(op, x, y, c, cyc);
         @(posedge clk);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || wr0 !== 1'b0 || wr1 !== 1'b0 ||
          paint_permanent !== 1'b0 || addr_write !== 12'h000 || wdata !== 12'h000) begin
         failed++;
         $display("FAIL %s got ready=%b busy=%b wr0=%b wr1=%b perm=%b addr=%h wdata=%h want 1 0 0 0 0 000 000",
                  tag, cmd_ready, busy, wr0, wr1, paint_permanent, addr_write, wdata);
      end
   endtask

   initial begin
      int w;
      rst       = 1'b1;
      fill      = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cursor_x  = '0;
      cursor_y  = '0;
      color     = '0;
      seed      = $urandom;
      for (int i = 0; i < 2048; i++) begin
         mm0[i] = init_val(0, i);
         mm1[i] = init_val(1, i);
      end
      m_drawn = 1'b0;
      m_ox    = '0;
      m_oy    = '0;
      repeat (3) @(negedge clk);
      rst  = 1'b0;
      fill = 1'b0;
      check_idle_outputs("reset_state");

      // Directed sequence.
      issue(2'b00, 6'd5, 6'd3, 12'h000);
      issue(2'b00, 6'd5, 6'd40, 12'h000);
      issue(2'b01, 6'd63, 6'd63, 12'hF00);
      issue(2'b10, 6'd0, 6'd0, 12'h00F);
      issue(2'b00, 6'd10, 6'd20, 12'h000);
      issue(2'b00, 6'd10, 6'd20, 12'h000);
      issue(2'b11, 6'd1, 6'd50, 12'hABC);
      issue(2'b00, 6'd33, 6'd33, 12'h000);

      // Reset in the middle of a clear.
      issue(2'b10, 6'd0, 6'd0, 12'h0F0);
      w = 0;
      while (addr_write !== 12'h100 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (addr_write !== 12'h100) begin
         failed++;
         $display("FAIL clear_reach_100 addr=%h want 100", addr_write);
      end
      cmd_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      m_drawn = 1'b0;
      m_ox    = '0;
      m_oy    = '0;
      @(negedge clk);
      rst = 1'b0;
      check_idle_outputs("reset_mid_clear");
      repeat (5) @(negedge clk);
      check_idle_outputs("quiet_after_abort");
      issue(2'b00, 6'd7, 6'd60, 12'h000);

      // Randomized commands.
      for (int k = 0; k < 40; k++) begin
         int r;
         logic [1:0] op;
         r  = $urandom_range(0, 24);
         op = (r == 0) ? 2'b10 : (r <= 3) ? 2'b11 : (r <= 13) ? 2'b00 : 2'b01;
         issue(op, 6'($urandom), 6'($urandom), 12'($urandom));
      end

      @(negedge clk);
      cmd_valid = 1'b0;
      w = 0;
      while (q.size() != 0 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      tests++;
      if (q.size() != 0) begin
         failed++;
         $display("FAIL drain pending=%0d want 0", q.size());
      end
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
